// File: rtl/acc_mean_div_pkg.sv
// Shared types and defaults for the running-mean divider.
package acc_mean_div_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // Width of an iteration counter that can hold 0..dw.
  function automatic int iter_w(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/div_serial_restoring.sv
// Serial restoring divider: one quotient bit per cycle, MSB first.
module div_serial_restoring
  import acc_mean_div_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [CNT_W-1:0]  divisor,
  output logic              busy,
  output logic              done,
  output logic              fin,
  output logic [DATA_W-1:0] quotient,
  output logic [CNT_W-1:0]  remainder,
  output logic              div0
);

  localparam int IW = iter_w(DATA_W);

  div_state_e        state;
  logic [DATA_W-1:0] quo;
  logic [CNT_W:0]    prem;
  logic [CNT_W-1:0]  dvs;
  logic [IW-1:0]     iter;
  logic [CNT_W:0]    shifted;
  logic [CNT_W:0]    diff;
  logic              qbit;

  always_comb begin
    shifted = {prem[CNT_W-1:0], quo[DATA_W-1]};
    diff    = shifted - {1'b0, dvs};
    qbit    = (shifted >= {1'b0, dvs});
  end

  // Final-step values; valid only while fin is high.
  assign fin       = (state == S_DIV) && (iter == IW'(DATA_W - 1));
  assign div0      = (dvs == '0);
  assign quotient  = div0 ? '1 : {quo[DATA_W-2:0], qbit};
  assign remainder = div0 ? '0 : (qbit ? diff[CNT_W-1:0] : shifted[CNT_W-1:0]);
  assign busy      = (state == S_DIV);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      quo   <= '0;
      prem  <= '0;
      dvs   <= '0;
      iter  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_DIV;
            quo   <= dividend;
            dvs   <= divisor;
            prem  <= '0;
            iter  <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DIV: begin
          quo  <= {quo[DATA_W-2:0], qbit};
          prem <= qbit ? diff : shifted;
          iter <= iter + IW'(1);
          if (fin) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/acc_mean_div.sv
// Sample counter plus snapshot divider producing mean = y / n of the |x| accumulator.
module acc_mean_div
  import acc_mean_div_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] y,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] mean,
  output logic [CNT_W-1:0]  rem,
  output logic [CNT_W-1:0]  n,
  output logic              div0
);

  logic              fin;
  logic [DATA_W-1:0] q_fin;
  logic [CNT_W-1:0]  r_fin;
  logic              z_fin;

  // Divider latches y and the registered n when it accepts start,
  // so an en in the same cycle is not part of the snapshot.
  div_serial_restoring #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (y),
    .divisor   (n),
    .busy      (busy),
    .done      (done),
    .fin       (fin),
    .quotient  (q_fin),
    .remainder (r_fin),
    .div0      (z_fin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      n    <= '0;
      mean <= '0;
      rem  <= '0;
      div0 <= 1'b0;
    end else begin
      if (clr)                 n <= '0;
      else if (en && n != '1)  n <= n + CNT_W'(1);
      // Written on the last divide step so they appear with done.
      if (fin) begin
        mean <= q_fin;
        rem  <= r_fin;
        div0 <= z_fin;
      end
    end
  end

endmodule

// File: tb/tb_acc_mean_div.sv
// Randomized bench for acc_mean_div with a cycle-level behavioural model.
module tb_acc_mean_div;

  localparam int DW   = 32;
  localparam int CW   = 16;
  localparam int NMAX = 65535;

  logic          clk = 1'b0;
  logic          rst, en, clr, start;
  logic [DW-1:0] y;
  logic          busy, done, div0;
  logic [DW-1:0] mean;
  logic [CW-1:0] rem, n;

  logic          en4, clr4, start4;
  logic          busy4, done4, div04;
  logic [DW-1:0] mean4;
  logic [3:0]    rem4, n4;

  always #5 clk = ~clk;

  acc_mean_div #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .y(y), .start(start),
    .busy(busy), .done(done), .mean(mean), .rem(rem), .n(n), .div0(div0)
  );

  acc_mean_div #(.DATA_W(DW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .clr(clr4), .y(y), .start(start4),
    .busy(busy4), .done(done4), .mean(mean4), .rem(rem4), .n(n4), .div0(div04)
  );

  int n_chk = 0;
  int n_fail = 0;
  int ndone = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1..DW busy, DW+1 done cycle.
  int     ph = 0;
  longint m_n = 0, m_n4 = 0, m_dvd = 0, m_dvs = 0;
  longint e_mean = 0, e_rem = 0, e_div0 = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_n <= 0; m_n4 <= 0; ph <= 0;
      e_mean <= 0; e_rem <= 0; e_div0 <= 0;
    end else begin
      if (clr) m_n <= 0;
      else if (en && m_n < NMAX) m_n <= m_n + 1;
      if (clr4) m_n4 <= 0;
      else if (en4 && m_n4 < 15) m_n4 <= m_n4 + 1;
      if (start && (ph == 0 || ph == DW + 1)) begin
        ph <= 1; m_dvd <= longint'(y); m_dvs <= m_n;
      end else if (ph >= 1 && ph <= DW) ph <= ph + 1;
      else ph <= 0;
      if (ph == DW) begin
        if (m_dvs == 0) begin
          e_mean <= 64'hFFFF_FFFF; e_rem <= 0; e_div0 <= 1;
        end else begin
          e_mean <= m_dvd / m_dvs; e_rem <= m_dvd % m_dvs; e_div0 <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done) ndone++;
    if (chk_on) begin
      chk("busy", busy, (ph >= 1 && ph <= DW) ? 1 : 0);
      chk("done", done, (ph == DW + 1) ? 1 : 0);
      chk("n", n, m_n);
      chk("n4", n4, m_n4);
      chk("mean", mean, e_mean);
      chk("rem", rem, e_rem);
      chk("div0", div0, e_div0);
    end
  end

  task automatic pulse_en(input int k);
    repeat (k) begin en = 1'b1; @(negedge clk); en = 1'b0; end
  endtask

  task automatic clear_n();
    clr = 1'b1; @(negedge clk); clr = 1'b0;
  endtask

  // Issue start in the current cycle; return cycles until done is seen.
  task automatic run_div(output int lat);
    start = 1'b1; @(negedge clk); start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin @(negedge clk); lat++; end
  endtask

  int     lat, nd0, x;
  longint sum;

  initial begin
    rst = 1; en = 0; clr = 0; y = '0; start = 0; en4 = 0; clr4 = 0; start4 = 0;
    @(posedge clk); @(negedge clk); @(negedge clk);
    chk_on = 1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_mean", mean, 0);
    chk("rst_rem", rem, 0);   chk("rst_n", n, 0);       chk("rst_div0", div0, 0);
    rst = 0;

    pulse_en(4);
    y = 32'd4000;
    run_div(lat);
    chk("t1_lat", lat, 33); chk("t1_mean", mean, 1000); chk("t1_rem", rem, 0);
    chk("t1_div0", div0, 0); chk("t1_n", n, 4);

    clear_n(); pulse_en(3); y = 32'd7;
    run_div(lat);
    chk("t2a_mean", mean, 2); chk("t2a_rem", rem, 1);
    clear_n(); pulse_en(1); y = 32'hFFFF_FFFF;
    run_div(lat);
    chk("t2b_mean", mean, 64'hFFFF_FFFF); chk("t2b_rem", rem, 0);

    clear_n(); y = 32'd12345;
    run_div(lat);
    chk("t3_lat", lat, 33); chk("t3_mean", mean, 64'hFFFF_FFFF);
    chk("t3_rem", rem, 0);  chk("t3_div0", div0, 1);
    run_div(lat);  // issued in the done cycle
    chk("t3_b2b_lat", lat, 33);

    clear_n(); pulse_en(5); y = 32'd100;
    nd0 = ndone;
    start = 1; @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    start = 1; en = 1; @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    en = 0;
    lat = 0;
    while (!done && lat < 200) begin @(negedge clk); lat++; end
    chk("t4_mean", mean, 20); chk("t4_rem", rem, 0); chk("t4_n", n, 8);
    repeat (40) @(negedge clk);
    chk("t4_ndone", ndone - nd0, 1);

    repeat (20) begin en4 = 1; @(negedge clk); en4 = 0; end
    chk("t5_sat", n4, 15);
    clr4 = 1; en4 = 1; @(negedge clk); clr4 = 0; en4 = 0;
    chk("t5_clr_pri", n4, 0);

    y = 32'd500;
    start = 1; @(negedge clk); start = 0;
    repeat (9) @(negedge clk);
    rst = 1; @(negedge clk);
    chk("t6_busy", busy, 0); chk("t6_mean", mean, 0); chk("t6_n", n, 0);
    rst = 0;
    nd0 = ndone;
    repeat (40) @(negedge clk);
    chk("t6_nodone", ndone - nd0, 0);

    y = '0; sum = 0;
    for (int i = 0; i < 101; i++) begin
      x = int'($urandom_range(0, 2047));
      en = 1;
      if ($urandom_range(0, 7) == 0) start = 1;
      @(negedge clk);
      en = 0; start = 0;
      sum += x;
      y = DW'(sum);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    lat = 0;
    while (busy && lat < 100) begin @(negedge clk); lat++; end
    chk("t6_idle", busy, 0);
    run_div(lat);
    chk("t6_rand_mean", mean, sum / 101); chk("t6_rand_rem", rem, sum % 101);
    chk("t6_rand_n", n, 101);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
